// File: rtl/inst_mem_loader_pkg.sv
// rtl/inst_mem_loader_pkg.sv - shared constants and loader state encoding
//
// Purpose: constants shared by the instruction-memory loader and the fetch
// stage: the end-of-program marker, the default instruction-memory depth and
// the loader state encoding.
package inst_mem_loader_pkg;

    localparam logic [31:0] HALT_INSTR     = 32'hFFFF_FFFF;
    localparam int          INST_MEM_DEPTH = 64;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } loader_state_e;

endpackage

// File: rtl/inst_mem_loader_byte_to_word_assembler.sv
// rtl/inst_mem_loader_byte_to_word_assembler.sv - packs a byte stream into big-endian 32-bit words
//
// Purpose: collects accepted bytes; the first byte of each group of four
// lands in bits 31:24. When the fourth byte is accepted the finished word is
// registered and o_word_valid pulses for exactly one cycle on the next cycle.
//
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   i_byte        incoming byte
//   i_accept      take i_byte this cycle
//   i_flush       discard any partial word (overrides i_accept)
//   o_word        last completed word, held until the next one completes
//   o_word_valid  one-cycle pulse: o_word has just been completed
module byte_to_word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_byte,
    input  logic        i_accept,
    input  logic        i_flush,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    // Only the three earlier bytes of a word need storing; the fourth is
    // merged directly into the completed word.
    logic [23:0] shift_q, shift_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    logic        valid_q, valid_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        valid_d = 1'b0;
        if (i_flush) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (i_accept) begin
            shift_d = {shift_q[15:0], i_byte};
            cnt_d   = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
                word_d  = {shift_q, i_byte};
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign o_word       = word_q;
    assign o_word_valid = valid_q;

endmodule

// File: rtl/inst_mem_loader.sv
// rtl/inst_mem_loader.sv - loads a UART byte stream into instruction memory and releases fetch
//
// Purpose: writes assembled words to consecutive instruction-memory addresses
// starting at 0. Loading ends on HALT_WORD (which is itself written) or after
// the word at MEM_DEPTH-1; the pipeline enable then rises and stays high until
// i_reload or rst.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   i_rx_data         byte from the UART receiver
//   i_rx_valid        i_rx_data is valid this cycle
//   i_reload          restart loading from address 0 on the next edge
//   o_write_inst_mem  instruction-memory write strobe
//   o_inst_mem_addr   word address (zero-extended)
//   o_inst_mem_data   instruction word
//   o_enable          pipeline/fetch enable
//   o_word_count      words written since the last load start
//   o_overflow        memory filled before HALT_WORD arrived
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          MEM_DEPTH  = INST_MEM_DEPTH,
    parameter logic [31:0] HALT_WORD  = HALT_INSTR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    input  logic                  i_reload,
    output logic                  o_write_inst_mem,
    output logic [31:0]           o_inst_mem_addr,
    output logic [DATA_WIDTH-1:0] o_inst_mem_data,
    output logic                  o_enable,
    output logic [31:0]           o_word_count,
    output logic                  o_overflow
);

    localparam int            AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_DEPTH - 1);

    loader_state_e state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] last_addr_q, last_addr_d;
    logic [31:0]   count_q, count_d;
    logic          overflow_q, overflow_d;

    logic [31:0]   word;
    logic          word_valid;
    logic          accept;

    // A byte sharing its cycle with i_reload belongs to the discarded program.
    assign accept = i_rx_valid && (state_q == LOAD) && !i_reload;

    byte_to_word_assembler u_assembler (
        .clk          (clk),
        .rst          (rst),
        .i_byte       (i_rx_data),
        .i_accept     (accept),
        .i_flush      (i_reload),
        .o_word       (word),
        .o_word_valid (word_valid)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        last_addr_d = last_addr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;

        // A word can only complete while loading: the cycle that moves to RUN
        // is the write cycle itself, and any byte taken then starts a new word.
        if (word_valid) begin
            count_d     = count_q + 32'd1;
            last_addr_d = addr_q;
            if (addr_q != LAST_ADDR) begin
                addr_d = addr_q + AW'(1);
            end
            if (word == HALT_WORD) begin
                state_d = RUN;
            end else if (addr_q == LAST_ADDR) begin
                state_d    = RUN;
                overflow_d = 1'b1;
            end
        end

        // Reload overrides the bookkeeping of a write that completes this cycle;
        // the write strobe itself has already gone out.
        if (i_reload) begin
            state_d     = LOAD;
            addr_d      = '0;
            last_addr_d = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LOAD;
            addr_q      <= '0;
            last_addr_q <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_addr_q <= last_addr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

    // During the write the live address is shown; afterwards the port keeps
    // the address of the last write instead of the already-incremented one.
    assign o_write_inst_mem = word_valid;
    assign o_inst_mem_addr  = {{(32 - AW){1'b0}}, (word_valid ? addr_q : last_addr_q)};
    assign o_inst_mem_data  = word;
    assign o_enable         = (state_q == RUN);
    assign o_word_count     = count_q;
    assign o_overflow       = overflow_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// tb/tb_inst_mem_loader.sv - bench for inst_mem_loader (depth 64 and depth 4 instances)
module tb_inst_mem_loader;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        reload = 1'b0;

    logic        a_write, a_en, a_ovf;
    logic [31:0] a_addr, a_data, a_cnt;
    logic        b_write, b_en, b_ovf;
    logic [31:0] b_addr, b_data, b_cnt;

    inst_mem_loader dut_a (
        .clk(clk), .rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid), .i_reload(reload),
        .o_write_inst_mem(a_write), .o_inst_mem_addr(a_addr), .o_inst_mem_data(a_data),
        .o_enable(a_en), .o_word_count(a_cnt), .o_overflow(a_ovf)
    );

    inst_mem_loader #(.MEM_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid), .i_reload(reload),
        .o_write_inst_mem(b_write), .o_inst_mem_addr(b_addr), .o_inst_mem_data(b_data),
        .o_enable(b_en), .o_word_count(b_cnt), .o_overflow(b_ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] cyc;
    } wr_t;

    wr_t        mon_a[$];
    wr_t        mon_b[$];
    wr_t        exp_w[$];
    int         en_a = -1;
    int         en_b = -1;
    int         exp_en;
    logic       exp_ovf;
    logic [7:0] acc_b[$];
    int         acc_e[$];
    int         checks = 0;
    int         failures = 0;

    // Writes are stamped with the edge count at which the strobe became visible.
    always @(negedge clk) begin
        if (a_write) mon_a.push_back(wr_t'{a_addr, a_data, 32'(cyc)});
        if (b_write) mon_b.push_back(wr_t'{b_addr, b_data, 32'(cyc)});
        if (a_en && en_a < 0) en_a = cyc;
        if (b_en && en_b < 0) en_b = cyc;
    end

    // Reference: group accepted bytes big-endian by four, address = word index,
    // each write visible right after its 4th byte's edge, enable one edge later,
    // stop at HALT or after the word at depth-1.
    function automatic void build_model(input int depth);
        logic [31:0] w;
        exp_w.delete();
        exp_en  = -1;
        exp_ovf = 1'b0;
        for (int i = 0; 4 * i + 3 < acc_b.size(); i++) begin
            w = {acc_b[4*i], acc_b[4*i+1], acc_b[4*i+2], acc_b[4*i+3]};
            exp_w.push_back(wr_t'{32'(i), w, 32'(acc_e[4*i+3])});
            if (w == HALT) begin
                exp_en = acc_e[4*i+3] + 1;
                break;
            end
            if (i == depth - 1) begin
                exp_ovf = 1'b1;
                exp_en  = acc_e[4*i+3] + 1;
                break;
            end
        end
    endfunction

    task automatic drive(input logic v, input logic [7:0] d, input logic r);
        @(posedge clk);
        #1;
        rx_valid = v;
        rx_data  = d;
        reload   = r;
        if (r) begin
            acc_b.delete();
            acc_e.delete();
        end else if (v) begin
            acc_b.push_back(d);
            acc_e.push_back(cyc + 1);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_max);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, w[31-8*k -: 8], 1'b0);
            if (gap_max > 0) idle($urandom_range(0, gap_max));
        end
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        w[31:24] = 8'($urandom_range(0, 254));
        return w;
    endfunction

    task automatic start();
        drive(1'b0, 8'h00, 1'b1);
        idle(2);
        mon_a.delete();
        mon_b.delete();
        en_a = -1;
        en_b = -1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if ({a_write, a_en, a_ovf, a_addr, a_data, a_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_a: got w=%b en=%b ov=%b addr=%h data=%h cnt=%0d want all zero",
                     a_write, a_en, a_ovf, a_addr, a_data, a_cnt);
        end
        checks++;
        if ({b_write, b_en, b_ovf, b_addr, b_data, b_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_b: got w=%b en=%b ov=%b addr=%h cnt=%0d want all zero",
                     b_write, b_en, b_ovf, b_addr, b_cnt);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2);
        checks++;
        if ({a_write, a_en, a_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_release: got w=%b en=%b cnt=%0d want 0", a_write, a_en, a_cnt);
        end
    endtask

    task automatic test_basic();
        wr_t got;
        start();
        send_word(32'h0000_000A, 2);
        send_word(32'h0000_0014, 2);
        send_word(32'hFFFF_FFFF, 2);
        idle(4);
        build_model(64);
        checks++;
        if (mon_a.size() !== 3) begin
            failures++;
            $display("FAIL basic_nwrites: got %0d want 3", mon_a.size());
        end
        foreach (exp_w[i]) begin
            got = (i < mon_a.size()) ? mon_a[i] : wr_t'(0);
            checks++;
            if (got !== exp_w[i]) begin
                failures++;
                $display("FAIL basic_write%0d: got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                         i, got.addr, got.data, got.cyc, exp_w[i].addr, exp_w[i].data, exp_w[i].cyc);
            end
        end
        checks++;
        if (en_a !== exp_en) begin
            failures++;
            $display("FAIL basic_enable_cycle: got %0d want %0d", en_a, exp_en);
        end
        checks++;
        if (a_cnt !== 32'd3 || a_ovf !== 1'b0 || a_en !== 1'b1) begin
            failures++;
            $display("FAIL basic_final: got cnt=%0d ovf=%b en=%b want cnt=3 ovf=0 en=1", a_cnt, a_ovf, a_en);
        end
    endtask

    task automatic test_byte_order();
        start();
        send_word(32'h1234_5678, 0);
        idle(3);
        checks++;
        if (mon_a.size() !== 1 || mon_a[0].addr !== 32'd0 || mon_a[0].data !== 32'h1234_5678) begin
            failures++;
            $display("FAIL byte_order: got n=%0d addr=%0d data=%h want n=1 addr=0 data=12345678",
                     mon_a.size(), (mon_a.size() > 0) ? mon_a[0].addr : 32'hx,
                     (mon_a.size() > 0) ? mon_a[0].data : 32'hx);
        end
        checks++;
        if (a_en !== 1'b0 || a_cnt !== 32'd1 || a_addr !== 32'd0) begin
            failures++;
            $display("FAIL byte_order_hold: got en=%b cnt=%0d addr=%0d want en=0 cnt=1 addr=0", a_en, a_cnt, a_addr);
        end
    endtask

    task automatic test_back_to_back();
        wr_t got;
        start();
        send_word(rand_word(), 0);
        send_word(rand_word(), 0);
        idle(3);
        build_model(64);
        checks++;
        if (mon_a.size() !== 2) begin
            failures++;
            $display("FAIL b2b_nwrites: got %0d want 2", mon_a.size());
        end
        foreach (exp_w[i]) begin
            got = (i < mon_a.size()) ? mon_a[i] : wr_t'(0);
            checks++;
            if (got !== exp_w[i]) begin
                failures++;
                $display("FAIL b2b_write%0d: got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                         i, got.addr, got.data, got.cyc, exp_w[i].addr, exp_w[i].data, exp_w[i].cyc);
            end
        end
        checks++;
        if (a_cnt !== 32'd2) begin
            failures++;
            $display("FAIL b2b_count: got %0d want 2", a_cnt);
        end
    endtask

    task automatic test_overflow();
        wr_t got;
        start();
        for (int i = 0; i < 4; i++) send_word(rand_word(), 1);
        idle(3);
        build_model(4);
        checks++;
        if (mon_b.size() !== 4 || exp_w.size() !== 4) begin
            failures++;
            $display("FAIL ovf_nwrites: got %0d want 4", mon_b.size());
        end
        foreach (exp_w[i]) begin
            got = (i < mon_b.size()) ? mon_b[i] : wr_t'(0);
            checks++;
            if (got !== exp_w[i]) begin
                failures++;
                $display("FAIL ovf_write%0d: got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                         i, got.addr, got.data, got.cyc, exp_w[i].addr, exp_w[i].data, exp_w[i].cyc);
            end
        end
        checks++;
        if (b_ovf !== 1'b1 || b_en !== 1'b1 || en_b !== exp_en || b_cnt !== 32'd4) begin
            failures++;
            $display("FAIL ovf_flags: got ovf=%b en=%b en_cyc=%0d cnt=%0d want ovf=1 en=1 en_cyc=%0d cnt=4",
                     b_ovf, b_en, en_b, b_cnt, exp_en);
        end
        send_word(rand_word(), 0);
        send_word(32'hFFFF_FFFF, 0);
        idle(3);
        checks++;
        if (mon_b.size() !== 4 || b_en !== 1'b1 || b_cnt !== 32'd4) begin
            failures++;
            $display("FAIL ovf_run_ignores: got n=%0d en=%b cnt=%0d want n=4 en=1 cnt=4", mon_b.size(), b_en, b_cnt);
        end
    endtask

    task automatic test_halt_at_last();
        start();
        for (int i = 0; i < 3; i++) send_word(rand_word(), 0);
        send_word(HALT, 0);
        idle(3);
        checks++;
        if (mon_b.size() !== 4 || b_ovf !== 1'b0 || b_en !== 1'b1 ||
            (mon_b.size() == 4 && (mon_b[3].addr !== 32'd3 || mon_b[3].data !== HALT))) begin
            failures++;
            $display("FAIL halt_at_last: got n=%0d ovf=%b en=%b want n=4 ovf=0 en=1 last=(3,ffffffff)",
                     mon_b.size(), b_ovf, b_en);
        end
    endtask

    task automatic test_reload_mid();
        start();
        drive(1'b1, 8'hAA, 1'b0);
        drive(1'b1, 8'hBB, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        send_word(32'h0000_0032, 0);
        idle(3);
        checks++;
        if (mon_a.size() !== 1 || mon_a[0].addr !== 32'd0 || mon_a[0].data !== 32'h0000_0032) begin
            failures++;
            $display("FAIL reload_mid: got n=%0d data=%h want n=1 addr=0 data=00000032",
                     mon_a.size(), (mon_a.size() > 0) ? mon_a[0].data : 32'hx);
        end
        start();
        drive(1'b1, 8'h11, 1'b0);
        drive(1'b1, 8'h22, 1'b0);
        drive(1'b1, 8'h33, 1'b0);
        drive(1'b1, 8'h44, 1'b1);
        send_word(32'h0102_0304, 1);
        idle(3);
        checks++;
        if (mon_a.size() !== 1 || mon_a[0].addr !== 32'd0 || mon_a[0].data !== 32'h0102_0304) begin
            failures++;
            $display("FAIL reload_same_cycle: got n=%0d data=%h want n=1 data=01020304",
                     mon_a.size(), (mon_a.size() > 0) ? mon_a[0].data : 32'hx);
        end
    endtask

    task automatic test_reload_during_write();
        start();
        send_word(32'h0000_0007, 0);
        send_word(32'h0000_0008, 0);
        drive(1'b0, 8'h00, 1'b1);
        idle(2);
        checks++;
        if (mon_a.size() !== 2 || (mon_a.size() == 2 && mon_a[1].data !== 32'h0000_0008)) begin
            failures++;
            $display("FAIL reload_write_completes: got n=%0d want 2 writes ending with 00000008", mon_a.size());
        end
        checks++;
        if (a_cnt !== 32'd0 || a_addr !== 32'd0 || a_en !== 1'b0) begin
            failures++;
            $display("FAIL reload_write_clears: got cnt=%0d addr=%0d en=%b want 0 0 0", a_cnt, a_addr, a_en);
        end
        mon_a.delete();
        send_word(32'h0000_0009, 0);
        idle(2);
        checks++;
        if (mon_a.size() !== 1 || (mon_a.size() == 1 && mon_a[0].addr !== 32'd0)) begin
            failures++;
            $display("FAIL reload_write_addr: got n=%0d addr=%0d want n=1 addr=0",
                     mon_a.size(), (mon_a.size() > 0) ? mon_a[0].addr : 32'hx);
        end
    endtask

    task automatic test_random();
        wr_t got;
        int  nw;
        for (int t = 0; t < 6; t++) begin
            start();
            nw = $urandom_range(1, 6);
            for (int i = 0; i < nw; i++)
                send_word(($urandom_range(0, 3) == 0) ? HALT : rand_word(), 2);
            idle(4);
            build_model(64);
            checks++;
            if (mon_a.size() !== exp_w.size() || en_a !== exp_en || a_ovf !== exp_ovf ||
                a_cnt !== 32'(exp_w.size())) begin
                failures++;
                $display("FAIL rand%0d_a_summary: got n=%0d en_cyc=%0d ovf=%b cnt=%0d want n=%0d en_cyc=%0d ovf=%b",
                         t, mon_a.size(), en_a, a_ovf, a_cnt, exp_w.size(), exp_en, exp_ovf);
            end
            foreach (exp_w[i]) begin
                got = (i < mon_a.size()) ? mon_a[i] : wr_t'(0);
                checks++;
                if (got !== exp_w[i]) begin
                    failures++;
                    $display("FAIL rand%0d_a_write%0d: got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                             t, i, got.addr, got.data, got.cyc, exp_w[i].addr, exp_w[i].data, exp_w[i].cyc);
                end
            end
            build_model(4);
            checks++;
            if (mon_b.size() !== exp_w.size() || en_b !== exp_en || b_ovf !== exp_ovf) begin
                failures++;
                $display("FAIL rand%0d_b_summary: got n=%0d en_cyc=%0d ovf=%b want n=%0d en_cyc=%0d ovf=%b",
                         t, mon_b.size(), en_b, b_ovf, exp_w.size(), exp_en, exp_ovf);
            end
            foreach (exp_w[i]) begin
                got = (i < mon_b.size()) ? mon_b[i] : wr_t'(0);
                checks++;
                if (got !== exp_w[i]) begin
                    failures++;
                    $display("FAIL rand%0d_b_write%0d: got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                             t, i, got.addr, got.data, got.cyc, exp_w[i].addr, exp_w[i].data, exp_w[i].cyc);
                end
            end
        end
    endtask

    task automatic test_async_rst();
        start();
        send_word(rand_word(), 0);
        send_word(HALT, 0);
        idle(3);
        checks++;
        if (a_en !== 1'b1 || a_cnt !== 32'd2 || a_addr !== 32'd1) begin
            failures++;
            $display("FAIL async_pre: got en=%b cnt=%0d addr=%0d want en=1 cnt=2 addr=1", a_en, a_cnt, a_addr);
        end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if (a_en !== 1'b0 || a_cnt !== 32'd0 || a_addr !== 32'd0 || b_en !== 1'b0) begin
            failures++;
            $display("FAIL async_rst_immediate: got en=%b cnt=%0d addr=%0d b_en=%b want 0 0 0 0",
                     a_en, a_cnt, a_addr, b_en);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        acc_b.delete();
        acc_e.delete();
        mon_a.delete();
        en_a = -1;
        send_word(32'h0000_0005, 0);
        idle(3);
        checks++;
        if (mon_a.size() !== 1 || a_en !== 1'b0 ||
            (mon_a.size() == 1 && (mon_a[0].addr !== 32'd0 || mon_a[0].data !== 32'h0000_0005))) begin
            failures++;
            $display("FAIL async_after_release: got n=%0d en=%b want one write (0,00000005) en=0",
                     mon_a.size(), a_en);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_order();
        test_back_to_back();
        test_overflow();
        test_halt_at_last();
        test_reload_mid();
        test_reload_during_write();
        test_random();
        test_async_rst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
